// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with a saturating synaptic-current accumulator.
// Optional adaptive threshold via `define LIF_ADAPT_THRESH_EN. Rev 1.0
`default_nettype none

module lif_neuron #(
  parameter int DW         = 16,
  parameter int ACC_W      = 20,
  parameter int V_TH       = 1000,
  parameter int V_RESET    = 0,
  parameter int V_MIN      = -2048,
  parameter int LEAK_SHIFT = 4,
  parameter int T_REF      = 2,
  parameter int TH_INC     = 200,
  parameter int ADAPT_MAX  = 4000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 syn_valid,
  input  logic signed [DW-1:0] syn_current,
  input  logic                 step,
  output logic                 spike_out,
  output logic signed [DW-1:0] v_mem,
  output logic                 refractory
);

  localparam int VW = ACC_W + 2;
  localparam int RW = (T_REF > 0) ? $clog2(T_REF + 1) : 1;

  localparam logic signed [VW-1:0] VMIN_X   = VW'(V_MIN);
  localparam logic signed [VW-1:0] VMAX_X   = VW'((1 << (DW - 1)) - 1);
  localparam logic signed [DW-1:0] V_RST_C  = DW'(V_RESET);
  localparam logic signed [DW-1:0] V_MIN_C  = DW'(V_MIN);
  localparam logic signed [DW-1:0] V_MAX_C  = DW'((1 << (DW - 1)) - 1);
  localparam logic signed [DW:0]   V_TH_X   = (DW + 1)'(V_TH);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INTEG = 2'd1,
    S_REFR  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [DW-1:0]    v_q, v_d;
  logic                    spike_q, spike_d;
  logic [RW-1:0]           refr_q, refr_d;

  logic signed [ACC_W:0]   cur_ext;
  logic signed [ACC_W:0]   acc_sum;
  logic signed [ACC_W-1:0] acc_sat;
  logic signed [VW-1:0]    v_ext, leak_ext, accv_ext, v_raw;
  logic signed [DW-1:0]    v_new;
  logic signed [DW:0]      v_new_x;
  logic signed [DW:0]      th;
  logic                    fire_cond;

  // Saturating accumulate: overflow shows up as disagreement of the two top sum bits.
  assign cur_ext = {{(ACC_W + 1 - DW){syn_current[DW-1]}}, syn_current};
  assign acc_sum = {acc_q[ACC_W-1], acc_q} + cur_ext;

  always_comb begin
    acc_sat = acc_sum[ACC_W-1:0];
    if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
      acc_sat = acc_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  assign v_ext    = {{(VW - DW){v_q[DW-1]}}, v_q};
  assign leak_ext = v_ext >>> LEAK_SHIFT;
  assign accv_ext = {{2{acc_q[ACC_W-1]}}, acc_q};
  assign v_raw    = v_ext - leak_ext + accv_ext;

  always_comb begin
    v_new = v_raw[DW-1:0];
    if (v_raw < VMIN_X) begin
      v_new = V_MIN_C;
    end else if (v_raw > VMAX_X) begin
      v_new = V_MAX_C;
    end
  end

  assign v_new_x   = {v_new[DW-1], v_new};
  assign fire_cond = (v_new_x >= th);

`ifdef LIF_ADAPT_THRESH_EN
  logic [DW-1:0] th_off_q, th_off_d;
  logic [DW:0]   th_sum;
  logic          fire_w, step_w;

  assign th     = $signed({1'b0, th_off_q}) + V_TH_X;
  assign th_sum = {1'b0, th_off_q} + (DW + 1)'(TH_INC);
  assign fire_w = en && (state_q == S_INTEG) && step && fire_cond;
  assign step_w = en && step && (state_q != S_IDLE);

  // A spike and a decay never coincide; the spike takes priority.
  always_comb begin
    th_off_d = th_off_q;
    if (fire_w) begin
      th_off_d = (th_sum > (DW + 1)'(ADAPT_MAX)) ? DW'(ADAPT_MAX) : th_sum[DW-1:0];
    end else if (step_w && (th_off_q != '0)) begin
      th_off_d = th_off_q - DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      th_off_q <= '0;
    end else begin
      th_off_q <= th_off_d;
    end
  end
`else
  assign th = V_TH_X;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    v_d     = v_q;
    spike_d = 1'b0;
    refr_d  = refr_q;
    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_INTEG;
        S_INTEG: begin
          if (step) begin
            // A current arriving with the strobe seeds the next timestep.
            acc_d = syn_valid ? cur_ext[ACC_W-1:0] : '0;
            if (fire_cond) begin
              spike_d = 1'b1;
              v_d     = V_RST_C;
              if (T_REF > 0) begin
                state_d = S_REFR;
                refr_d  = RW'(T_REF);
              end
            end else begin
              v_d = v_new;
            end
          end else if (syn_valid) begin
            acc_d = acc_sat;
          end
        end
        S_REFR: begin
          acc_d = '0;
          v_d   = V_RST_C;
          if (step) begin
            refr_d = refr_q - RW'(1);
            if (refr_q == RW'(1)) begin
              state_d = S_INTEG;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      v_q     <= V_RST_C;
      spike_q <= 1'b0;
      refr_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      v_q     <= v_d;
      spike_q <= spike_d;
      refr_q  <= refr_d;
    end
  end

  assign spike_out  = spike_q;
  assign v_mem      = v_q;
  assign refractory = (state_q == S_REFR);

endmodule

`default_nettype wire

// File: tb/tb_lif_neuron.sv
// Table-driven bench for lif_neuron (default build) with an expected-result queue.
`default_nettype none

module tb_lif_neuron;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               syn_valid;
  logic signed [15:0] syn_current;
  logic               step;
  logic               spike_out;
  logic signed [15:0] v_mem;
  logic               refractory;

  lif_neuron dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .syn_valid   (syn_valid),
    .syn_current (syn_current),
    .step        (step),
    .spike_out   (spike_out),
    .v_mem       (v_mem),
    .refractory  (refractory)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rep;
    bit en;
    bit sv;
    int cur;
    bit st;
    bit exp_spk;
    int exp_v;
    bit exp_ref;
  } vec_t;

  typedef struct {
    int idx;
    bit spk;
    int v;
    bit rf;
  } exp_t;

  localparam int NV = 30;
  vec_t tbl[NV];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic compare_top(input exp_t e);
    n_checks++;
    if (spike_out !== e.spk)
      $display("FAIL row%0d spike_out got %0b want %0b", e.idx, spike_out, e.spk);
    else n_pass++;
    n_checks++;
    if (v_mem !== 16'(e.v))
      $display("FAIL row%0d v_mem got %0d want %0d", e.idx, v_mem, e.v);
    else n_pass++;
    n_checks++;
    if (refractory !== e.rf)
      $display("FAIL row%0d refractory got %0b want %0b", e.idx, refractory, e.rf);
    else n_pass++;
  endtask

  task automatic apply(input int idx);
    exp_t e;
    e.idx = idx;
    e.spk = tbl[idx].exp_spk;
    e.v   = tbl[idx].exp_v;
    e.rf  = tbl[idx].exp_ref;
    exp_q.push_back(e);
    for (int i = 0; i < tbl[idx].rep; i++) begin
      @(negedge clk);
      en          = tbl[idx].en;
      syn_valid   = tbl[idx].sv;
      syn_current = 16'(tbl[idx].cur);
      step        = tbl[idx].st;
      @(posedge clk);
    end
    #1;
    e = exp_q.pop_front();
    compare_top(e);
  endtask

  task automatic set_row(input int i, input int rep, input bit en_v, input bit sv,
                         input int cur, input bit st, input bit spk, input int v, input bit rf);
    tbl[i].rep = rep; tbl[i].en = en_v; tbl[i].sv = sv; tbl[i].cur = cur; tbl[i].st = st;
    tbl[i].exp_spk = spk; tbl[i].exp_v = v; tbl[i].exp_ref = rf;
  endtask

  initial begin
    exp_t e;
    //          rep en sv  cur    st  spk  v      ref
    set_row( 0,  1, 1, 0,     0, 0,  0,     0, 0);
    set_row( 1,  3, 1, 1,   400, 0,  0,     0, 0);
    set_row( 2,  1, 1, 0,     0, 1,  1,     0, 1);
    set_row( 3,  1, 1, 1,  2000, 0,  0,     0, 1);
    set_row( 4,  1, 1, 1,  2000, 1,  0,     0, 1);
    set_row( 5,  1, 1, 1,  2000, 0,  0,     0, 1);
    set_row( 6,  1, 1, 1,  2000, 1,  0,     0, 0);
    set_row( 7,  1, 1, 1,  2000, 0,  0,     0, 0);
    set_row( 8,  1, 1, 0,     0, 1,  1,     0, 1);
    set_row( 9,  1, 1, 0,     0, 1,  0,     0, 1);
    set_row(10,  1, 1, 0,     0, 1,  0,     0, 0);
    set_row(11,  1, 1, 1,   800, 0,  0,     0, 0);
    set_row(12,  1, 1, 0,     0, 1,  0,   800, 0);
    set_row(13,  1, 1, 0,     0, 1,  0,   750, 0);
    set_row(14,  1, 1, 1, -1504, 0,  0,   750, 0);
    set_row(15,  1, 1, 0,     0, 1,  0,  -800, 0);
    set_row(16,  1, 1, 0,     0, 1,  0,  -750, 0);
    set_row(17,  1, 1, 1,   100, 1,  0,  -703, 0);
    set_row(18,  1, 1, 0,     0, 1,  0,  -559, 0);
    set_row(19,  1, 1, 1, -5000, 0,  0,  -559, 0);
    set_row(20,  1, 0, 0,     0, 1,  0,  -559, 0);
    set_row(21,  1, 0, 1,  1234, 0,  0,  -559, 0);
    set_row(22,  1, 1, 0,     0, 0,  0,  -559, 0);
    set_row(23,  1, 1, 0,     0, 1,  0, -2048, 0);
    set_row(24, 20, 1, 1, 32767, 0,  0, -2048, 0);
    set_row(25,  1, 1, 0,     0, 1,  1,     0, 1);
    // after the mid-refractory reset pulse
    set_row(26,  1, 1, 0,     0, 0,  0,     0, 0);
    set_row(27,  3, 1, 1,   400, 0,  0,     0, 0);
    set_row(28,  1, 1, 0,     0, 1,  1,     0, 1);
    set_row(29,  1, 1, 0,     0, 0,  0,     0, 1);

    rst = 1'b0; en = 1'b0; syn_valid = 1'b0; syn_current = '0; step = 1'b0;
    #12;
    e.idx = -1; e.spk = 1'b0; e.v = 0; e.rf = 1'b0;
    exp_q.push_back(e);
    e = exp_q.pop_front();
    compare_top(e);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i <= 25; i++) apply(i);

    // Asynchronous reset between edges while a spike is showing and the neuron is refractory.
    #1;
    rst = 1'b0;
    #1;
    e.idx = -2; e.spk = 1'b0; e.v = 0; e.rf = 1'b0;
    exp_q.push_back(e);
    e = exp_q.pop_front();
    compare_top(e);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 26; i < NV; i++) apply(i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Leaky integrate-and-fire neuron stage, directly downstream of the synapse array.
- Accumulates signed synaptic currents (the synapse weighted-spike outputs) during a timestep.
- On each timestep strobe, applies leak, integrates, thresholds and fires.
- Its 1-bit spike output drives pre_spiking of the next layer's synapses.

Parameters:
- DW, 16, membrane/current width (signed).
- ACC_W, 20, current accumulator width (signed, ACC_W > DW).
- V_TH, 1000, base firing threshold (signed DW).
- V_RESET, 0, membrane value after a spike and during refractory.
- V_MIN, -2048, membrane floor (signed DW).
- LEAK_SHIFT, 4, leak = v_mem >>> LEAK_SHIFT (arithmetic shift).
- T_REF, 2, refractory length in timesteps (0 = none).
- TH_INC, 200, adaptive threshold increment per spike (used only with the optional feature).
- ADAPT_MAX, 4000, adaptive threshold ceiling (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- en  in  1  neuron enable
- syn_valid  in  1  syn_current is valid this cycle
- syn_current  in  DW  signed synaptic current (the synapse spking_value)
- step  in  1  one-cycle timestep strobe
- spike_out  out  1  one-cycle spike pulse
- v_mem  out  DW  signed membrane potential (registered)
- refractory  out  1  high while state = REFRACT

Behaviour:
- Reset (rst=0, async):
  - acc = 0, v_mem = V_RESET, spike_out = 0, refr_cnt = 0, state = IDLE.
  - Adaptive offset = 0.
  - On release, state moves IDLE -> INTEGRATE on the first clock with en=1.
- States:
  - IDLE: en=0. Nothing updates, except that spike_out is forced to 0. Any state goes to IDLE when en=0. IDLE -> INTEGRATE when en=1.
  - INTEGRATE: if syn_valid, acc <= sat_ACC(acc + sext(syn_current)); saturates at +/-2^(ACC_W-1) bounds.
  - INTEGRATE on step:
    - v_new = v_mem - (v_mem >>> LEAK_SHIFT) + acc, computed in ACC_W+2 bits.
    - v_new is clamped to [V_MIN, 2^(DW-1)-1].
    - acc <= 0.
    - If v_new >= threshold: spike_out <= 1, v_mem <= V_RESET. Go to REFRACT with refr_cnt <= T_REF if T_REF>0, else stay in INTEGRATE.
    - Otherwise v_mem <= v_new.
  - FIRE: not a separate state. The spike is the registered pulse issued on the step cycle.
    - spike_out is high exactly one cycle: the cycle after the step edge.
  - REFRACT:
    - syn_valid inputs are discarded; acc is held at 0.
    - v_mem is held at V_RESET.
    - Each step decrements refr_cnt. The step that brings refr_cnt to 0 returns to INTEGRATE; that step does no integration.
    - With T_REF=2, the next 2 steps are ignored.
- Latency: step at edge t -> spike_out / v_mem update visible after edge t.
- Simultaneous syn_valid and step:
  - The current is excluded from this step's sum.
  - It is loaded as the new acc value (acc <= sext(syn_current), not cleared).
- step while en=0: ignored. acc and v_mem are retained.
- Threshold = V_TH (+ adaptive offset when the optional feature is compiled in). Comparison is signed.

Optional Feature:
- Macro: LIF_ADAPT_THRESH_EN.
- Defined:
  - Register th_off (DW bits, reset 0); threshold = V_TH + th_off.
  - On each spike: th_off <= min(th_off + TH_INC, ADAPT_MAX).
  - On each non-spiking step with th_off > 0: th_off decrements by 1.
  - A spike and a decay never apply on the same step; the spike wins.
- Undefined: threshold is the constant V_TH; no th_off register is present.

Test Plan:
- Integrate and fire (defaults):
  - Stimulus: reset, en=1, three syn_valid currents of 400, then step.
  - Required: spike_out=1 for one cycle after the step; v_mem=0; refractory=1.
- Refractory (after the previous scenario):
  - Stimulus: syn_current 2000 each cycle, 3 steps.
  - Required: steps 1-2 produce no spike and v_mem=0; refractory drops after step 2; step 3 integrates only currents received after step 2 and spikes.
- Leak:
  - Stimulus: integrate 800 (no spike), then a step with no input, then a step with 0 input from -800.
  - Required: v_mem 800 -> 750; negative case -800 -> -750.
- Saturation and floor:
  - Stimulus A: 20 consecutive currents of 32767, then step.
  - Required A: acc saturates at 524287; v_mem clamps to 32767 before the threshold check; spike fires.
  - Stimulus B: currents of -5000, then step.
  - Required B: v_mem = -2048.
- Async reset mid-refractory:
  - Stimulus: rst low for 1 cycle between edges.
  - Required: immediately spike_out=0, v_mem=0, refractory=0; the next step after release (en=1) integrates normally.
- Adaptive threshold (macro defined):
  - Stimulus: repeated 1100-current steps with T_REF=0.
  - Required: first step spikes (th_off=200); second step's v_new 1100 < 1200, so no spike, th_off=199; th_off never exceeds 4000.
